// File: rtl/conv_mem_pkg.sv
// Shared types and helpers for the conv engine M-port memory responder.
package conv_mem_pkg;

   localparam int WORD_W = 32;
   localparam int LANES  = 4;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   // Per byte lane: strobed lanes take new_word, the rest keep old_word.
   function automatic logic [WORD_W-1:0] byte_merge(
      input logic [WORD_W-1:0] old_word,
      input logic [WORD_W-1:0] new_word,
      input logic [LANES-1:0]  strb
   );
      logic [WORD_W-1:0] res;
      res = old_word;
      for (int i = 0; i < LANES; i++) begin
         if (strb[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/conv_mem_responder_if.sv
// M-port bundle between a conv engine requester (master) and a memory responder (slave).
interface conv_mem_responder_if #(
   parameter int CNT_W = 16
);
   import conv_mem_pkg::*;

   logic               R_req;
   logic [LANES-1:0]   W_req;
   logic [31:0]        addr;
   logic [WORD_W-1:0]  W_data;
   logic [WORD_W-1:0]  R_data;
   logic               ready;
   logic               err;
   logic [CNT_W-1:0]   wr_cnt;

   modport master (
      output R_req, W_req, addr, W_data,
      input  R_data, ready, err, wr_cnt
   );

   modport slave (
      input  R_req, W_req, addr, W_data,
      output R_data, ready, err, wr_cnt
   );

endinterface

// File: rtl/conv_mem_array.sv
// Single-port word SRAM model: per-byte write enables, registered read of the pre-write word.
module conv_mem_array
   import conv_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic              clk,
   input  logic [LANES-1:0]  we,
   input  logic              re,
   input  logic [AW-1:0]     idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
   logic [WORD_W-1:0] rdata_q;

   // Byte-lane writes; the read samples the old word on the same edge.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we[i]) begin
            mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) begin
         rdata_q <= mem_q[idx];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/conv_mem_responder.sv
// Memory-side responder for the conv engine M-port: zero-fill after reset, then byte-masked
// writes and 1-cycle reads. Optional macro CONV_MEM_WR_FWD_EN forwards same-cycle write data.
module conv_mem_responder
   import conv_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int CNT_W       = 16
) (
   input  logic clk,
   input  logic rst,
   conv_mem_responder_if.slave bus
);

   localparam int               AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH_WORDS - 1);
   localparam logic [29:0]      DEPTH_30 = 30'(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e            state_q, state_d;
   logic [AW-1:0]     clr_idx_q, clr_idx_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic              zero_q, zero_d;
   logic [WORD_W-1:0] fwd_data_q, fwd_data_d;
   logic [LANES-1:0]  fwd_strb_q, fwd_strb_d;

   logic [29:0]       word_idx_s;
   logic              in_range_s;
   logic              req_s;
   logic [LANES-1:0]  arr_we_s;
   logic              arr_re_s;
   logic [AW-1:0]     arr_idx_s;
   logic [WORD_W-1:0] arr_wdata_s;
   logic [WORD_W-1:0] arr_rdata_s;
   logic              unused_s;

   assign word_idx_s = bus.addr[31:2];
   assign unused_s   = ^bus.addr[1:0];
   assign in_range_s = (word_idx_s < DEPTH_30);
   assign req_s      = bus.R_req | (bus.W_req != 4'b0000);

   // Next state, clear sequencing, request handling and array port muxing.
   always_comb begin
      state_d     = state_q;
      clr_idx_d   = clr_idx_q;
      ready_d     = ready_q;
      err_d       = err_q;
      wr_cnt_d    = wr_cnt_q;
      zero_d      = zero_q;
      fwd_data_d  = fwd_data_q;
      fwd_strb_d  = fwd_strb_q;
      arr_we_s    = 4'b0000;
      arr_re_s    = 1'b0;
      arr_idx_s   = word_idx_s[AW-1:0];
      arr_wdata_s = bus.W_data;

      if (!rst) begin
         state_d   = CLEAR;
         clr_idx_d = {AW{1'b0}};
         ready_d   = 1'b0;
         err_d     = 1'b0;
         wr_cnt_d  = {CNT_W{1'b0}};
         zero_d    = 1'b1;
      end else begin
         case (state_q)
            CLEAR: begin
               arr_we_s    = 4'b1111;
               arr_idx_s   = clr_idx_q;
               arr_wdata_s = {WORD_W{1'b0}};
               if (clr_idx_q == LAST_IDX) begin
                  state_d = READY;
                  ready_d = 1'b1;
               end else begin
                  clr_idx_d = clr_idx_q + AW'(1);
               end
            end
            READY: begin
               if (req_s && in_range_s) begin
                  if (bus.W_req != 4'b0000) begin
                     arr_we_s = bus.W_req;
                     if (wr_cnt_q != CNT_MAX) begin
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                     end else begin
                        wr_cnt_d = wr_cnt_q;
                     end
                  end else begin
                     arr_we_s = 4'b0000;
                  end
                  if (bus.R_req) begin
                     arr_re_s   = 1'b1;
                     zero_d     = 1'b0;
                     fwd_data_d = bus.W_data;
`ifdef CONV_MEM_WR_FWD_EN
                     fwd_strb_d = bus.W_req;
`else
                     fwd_strb_d = 4'b0000;
`endif
                  end else begin
                     arr_re_s = 1'b0;
                  end
               end else if (req_s) begin
                  // Out of range: drop the write, read returns zero, flag sticks.
                  err_d = 1'b1;
                  if (bus.R_req) begin
                     zero_d = 1'b1;
                  end else begin
                     zero_d = zero_q;
                  end
               end else begin
                  err_d = err_q;
               end
            end
            default: begin
               state_d   = CLEAR;
               clr_idx_d = {AW{1'b0}};
               ready_d   = 1'b0;
            end
         endcase
      end
   end

   // Control and status registers; reset is applied through the _d path.
   always_ff @(posedge clk) begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      wr_cnt_q   <= wr_cnt_d;
      zero_q     <= zero_d;
      fwd_data_q <= fwd_data_d;
      fwd_strb_q <= fwd_strb_d;
   end

   conv_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .we    (arr_we_s),
      .re    (arr_re_s),
      .idx   (arr_idx_s),
      .wdata (arr_wdata_s),
      .rdata (arr_rdata_s)
   );

   // Read data is built only from registered state, so it holds between reads.
   assign bus.R_data = zero_q ? {WORD_W{1'b0}} : byte_merge(arr_rdata_s, fwd_data_q, fwd_strb_q);
   assign bus.ready  = ready_q;
   assign bus.err    = err_q;
   assign bus.wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_conv_mem_responder.sv
// Scoreboard bench for conv_mem_responder: directed traffic, read data checked by a monitor.
module tb_conv_mem_responder;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   logic [31:0] sb_q [$];
   logic        mon_fire;

   conv_mem_responder_if #(.CNT_W(16)) bus ();

   conv_mem_responder #(
      .DEPTH_WORDS (1024),
      .CNT_W       (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) mon_fire <= bus.R_req;

   // Monitor: every edge that carried R_req owes one R_data comparison.
   always @(negedge clk) begin
      logic [31:0] exp;
      if (mon_fire) begin
         tests++;
         if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_underflow: R_data=%08h with no expected value queued", bus.R_data);
         end else begin
            exp = sb_q.pop_front();
            if (bus.R_data !== exp) begin
               fails++;
               $display("FAIL rdata: got %08h expected %08h at %0t", bus.R_data, exp, $time);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp);
      bus.R_req  = r;
      bus.W_req  = w;
      bus.addr   = a;
      bus.W_data = d;
      if (r) sb_q.push_back(exp);
      @(posedge clk);
      #1;
      bus.R_req = 1'b0;
      bus.W_req = 4'b0000;
   endtask

   // Runs with rst high until ready or max edges; early cycles carry ignored traffic.
   task automatic clear_cycles(input int max, output int n);
      n = 0;
      while (n < max) begin
         if (n < 20) begin
            bus.R_req  = 1'b1;
            bus.W_req  = 4'b1111;
            bus.addr   = (n % 2 == 1) ? 32'h0000_1000 : 32'(n * 4);
            bus.W_data = 32'hFFFF_FFFF;
            sb_q.push_back(32'h0000_0000);
         end else begin
            bus.R_req = 1'b0;
            bus.W_req = 4'b0000;
         end
         @(posedge clk);
         #1;
         n++;
         if (bus.ready) break;
      end
      bus.R_req = 1'b0;
      bus.W_req = 4'b0000;
   endtask

   localparam logic [31:0] EXP_W7 =
`ifdef CONV_MEM_WR_FWD_EN
      32'h0000_0009;
`else
      32'h0000_0005;
`endif

   localparam logic [31:0] EXP_W8 =
`ifdef CONV_MEM_WR_FWD_EN
      32'h1111_AB11;
`else
      32'h1111_1111;
`endif

   initial begin
      int n;
      tests      = 0;
      fails      = 0;
      rst        = 1'b0;
      bus.R_req  = 1'b0;
      bus.W_req  = 4'b0000;
      bus.addr   = 32'h0000_0000;
      bus.W_data = 32'h0000_0000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'h0, bus.ready}, 32'h0);
      check("rst_err", {31'h0, bus.err}, 32'h0);
      check("rst_wr_cnt", {16'h0, bus.wr_cnt}, 32'h0);
      check("rst_rdata", bus.R_data, 32'h0);

      rst = 1'b1;
      clear_cycles(2000, n);
      check("clear_len_first", 32'(n), 32'd1024);
      check("clear_wr_cnt", {16'h0, bus.wr_cnt}, 32'h0);
      check("clear_err", {31'h0, bus.err}, 32'h0);

      drive(1'b0, 4'b1111, 32'h0000_0FFC, 32'hDEAD_BEEF, 32'h0);
      drive(1'b1, 4'b0000, 32'h0000_0FFC, 32'h0, 32'hDEAD_BEEF);
      check("wr_cnt_pre", {16'h0, bus.wr_cnt}, 32'd1);

      // Reset with a request pending, 500 clear cycles, then a second reset pulse.
      rst = 1'b0;
      drive(1'b1, 4'b1111, 32'h0000_0FFC, 32'h1234_5678, 32'h0);
      rst = 1'b1;
      clear_cycles(500, n);
      check("mid_clear_ready", {31'h0, bus.ready}, 32'h0);
      check("mid_clear_n", 32'(n), 32'd500);
      rst = 1'b0;
      drive(1'b1, 4'b0000, 32'h0000_0000, 32'h0, 32'h0);
      rst = 1'b1;
      clear_cycles(2000, n);
      check("clear_len_rerun", 32'(n), 32'd1024);
      check("rerun_wr_cnt", {16'h0, bus.wr_cnt}, 32'h0);
      check("rerun_err", {31'h0, bus.err}, 32'h0);

      drive(1'b1, 4'b0000, 32'h0000_0FFC, 32'h0, 32'h0);

      drive(1'b0, 4'b1111, 32'h0000_0C5C, 32'h0001_8000, 32'h0);
      check("wr_cnt_one", {16'h0, bus.wr_cnt}, 32'd1);
      drive(1'b1, 4'b0000, 32'h0000_0C5C, 32'h0, 32'h0001_8000);

      drive(1'b0, 4'b1111, 32'h0000_0014, 32'hAABB_CCDD, 32'h0);
      drive(1'b0, 4'b0101, 32'h0000_0014, 32'h1122_3344, 32'h0);
      check("wr_cnt_mask", {16'h0, bus.wr_cnt}, 32'd3);
      drive(1'b1, 4'b0000, 32'h0000_0014, 32'h0, 32'hAA22_CC44);
      drive(1'b0, 4'b0000, 32'h0000_0014, 32'h0, 32'h0);
      check("rdata_hold", bus.R_data, 32'hAA22_CC44);

      drive(1'b0, 4'b1111, 32'h0000_001C, 32'h0000_0005, 32'h0);
      drive(1'b1, 4'b1111, 32'h0000_001C, 32'h0000_0009, EXP_W7);
      drive(1'b1, 4'b0000, 32'h0000_001C, 32'h0, 32'h0000_0009);

      drive(1'b0, 4'b1111, 32'h0000_0020, 32'h1111_1111, 32'h0);
      drive(1'b1, 4'b0010, 32'h0000_0020, 32'h0000_AB00, EXP_W8);
      drive(1'b1, 4'b0000, 32'h0000_0020, 32'h0, 32'h1111_AB11);
      check("wr_cnt_pre_oor", {16'h0, bus.wr_cnt}, 32'd7);
      check("err_pre_oor", {31'h0, bus.err}, 32'h0);

      drive(1'b1, 4'b1111, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0);
      check("oor_err", {31'h0, bus.err}, 32'h1);
      check("oor_wr_cnt", {16'h0, bus.wr_cnt}, 32'd7);
      drive(1'b1, 4'b0000, 32'h0000_0000, 32'h0, 32'h0);

      drive(1'b0, 4'b1111, 32'h0000_0004, 32'h1234_5678, 32'h0);
      drive(1'b1, 4'b0000, 32'h0000_0004, 32'h0, 32'h1234_5678);
      drive(1'b1, 4'b0000, 32'hFFFF_FFF0, 32'h0, 32'h0);
      check("err_sticky", {31'h0, bus.err}, 32'h1);
      check("wr_cnt_final", {16'h0, bus.wr_cnt}, 32'd8);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
